mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, maximum consecutive data grants while fetch is pending
- TIMEOUT, 255, memory-ack wait limit in cycles
REQ-002 Ports (name  direction  width  meaning):
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_f_req  in  1  fetch request, held until o_f_ack
- i_f_addr  in  ADDR_W  fetch address
- o_f_ack  out  1  fetch done pulse
- o_f_rdata  out  DATA_W  fetched instruction
- o_f_stall  out  1  fetch must hold
- i_flush  in  1  abort current/pending fetch
- i_d_req  in  1  load/store request, held until o_d_ack
- i_d_we  in  1  store=1
- i_d_addr  in  ADDR_W  data address
- i_d_wdata  in  DATA_W  store data
- i_d_wstrb  in  DATA_W/8  byte enables
- o_d_ack  out  1  data done pulse
- o_d_rdata  out  DATA_W  load data
- o_d_stall  out  1  data stage must hold
- o_m_req, o_m_we, o_m_addr, o_m_wdata, o_m_wstrb  out  1/1/ADDR_W/DATA_W/DATA_W/8  shared memory port
- i_m_ack  in  1  memory completion
- i_m_rdata  in  DATA_W  memory read data
- o_bus_err  out  1  timeout pulse

Function
REQ-003 FSM states are IDLE, FETCH, DATA, DRAIN; exactly one transaction is outstanding at a time.
REQ-004 In IDLE, a request sampled at a clock edge enters FETCH or DATA; o_m_req and the latched address, data and strobes are driven from the next cycle and held stable until i_m_ack.
REQ-005 Arbitration: data wins over fetch, except when the starve counter equals STARVE_MAX and i_f_req is high, in which case fetch wins.
REQ-006 Starve counter behaviour:
- increments on each data grant while i_f_req is high
- clears on a fetch grant or when i_f_req is low
- saturates at STARVE_MAX
REQ-007 On i_m_ack in FETCH or DATA:
- capture i_m_rdata into o_f_rdata or o_d_rdata (loads only)
- pulse the matching ack for one cycle on the following cycle
- return to IDLE
- minimum request-to-ack latency is 2 cycles plus memory wait states
REQ-008 A new grant may be issued in the same cycle as an ack pulse (back-to-back, no idle bubble).
REQ-009 o_f_stall = i_f_req & ~o_f_ack, and o_d_stall = i_d_req & ~o_d_ack, both combinational.
REQ-010 Flush handling:
- i_flush in FETCH moves the FSM to DRAIN
- DRAIN waits for i_m_ack, discards the data, gives no o_f_ack, then goes to IDLE
- i_flush in IDLE suppresses a fetch grant that cycle
- i_flush has no effect on DATA
REQ-011 i_flush coincident with i_m_ack in FETCH: data is discarded, no o_f_ack, FSM goes to IDLE.
REQ-012 Timeout counter behaviour:
- resets on each grant and counts cycles in FETCH, DATA or DRAIN
- on reaching TIMEOUT: o_m_req drops, o_bus_err pulses one cycle, FSM goes to IDLE
- the requester still receives its ack with read data 0; no ack is given from DRAIN
REQ-013 i_m_ack in IDLE is ignored.
REQ-014 Requests that drop before their ack are not tracked; the latched transaction completes and the ack is still pulsed.

Reset
REQ-015 Asynchronous assertion of i_rst_n forces the following, with no pending ack surviving:
- state IDLE
- o_m_req, o_m_we, o_f_ack, o_d_ack, o_bus_err = 0
- o_m_addr, o_m_wdata, o_m_wstrb, o_f_rdata, o_d_rdata = 0
- starve and timeout counters = 0
REQ-016 Reset mid-transaction abandons it; after release the FSM starts in IDLE and stale i_m_ack is ignored per REQ-013.

Structure
REQ-017 The state enum and default parameter constants live in the shared core package.
REQ-018 The timeout counter is a sub-module, mem_timeout_ctr (load, enable, expire outputs); all other logic is in one module.

Verification
REQ-019 Fetch only:
- stimulus: i_f_req=1, addr 0x100, memory acks after 3 wait cycles with 0x00000013
- response: o_f_ack pulses 5 cycles after request; o_f_rdata=0x13
REQ-020 Simultaneous requests with STARVE_MAX=2:
- stimulus: continuous data requests plus a pending fetch
- response: grant order D,D,F,D,D,F
REQ-021 Flush mid-fetch:
- stimulus: i_flush one cycle after grant, memory acks 2 cycles later
- response: no o_f_ack; next grant occurs the cycle after that ack
REQ-022 Timeout with TIMEOUT=8:
- stimulus: data load, memory never acks
- response: o_bus_err and o_d_ack pulse together; o_d_rdata=0; o_m_req low
REQ-023 Store:
- stimulus: i_d_we=1, wstrb 4'b0011, wdata 0xDEADBEEF
- response: memory port shows identical values held until ack; o_d_rdata unchanged
REQ-024 Reset mid-DATA:
- stimulus: assert i_rst_n low for 1 cycle
- response: all outputs 0 immediately; late i_m_ack produces no ack

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and default parameters
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_STARVE_MAX = 4;
  localparam int unsigned DEF_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - memory-ack wait counter; expires on the TIMEOUT-th enabled cycle
module mem_timeout_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  assign o_expire = i_en & (cnt_q == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= '0;
    end else if (i_en && !o_expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one memory port, one transaction outstanding
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_f_req,
  input  logic [ADDR_W-1:0]   i_f_addr,
  output logic                o_f_ack,
  output logic [DATA_W-1:0]   o_f_rdata,
  output logic                o_f_stall,
  input  logic                i_flush,
  input  logic                i_d_req,
  input  logic                i_d_we,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic [DATA_W/8-1:0] i_d_wstrb,
  output logic                o_d_ack,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_d_stall,
  output logic                o_m_req,
  output logic                o_m_we,
  output logic [ADDR_W-1:0]   o_m_addr,
  output logic [DATA_W-1:0]   o_m_wdata,
  output logic [DATA_W/8-1:0] o_m_wstrb,
  input  logic                i_m_ack,
  input  logic [DATA_W-1:0]   i_m_rdata,
  output logic                o_bus_err
);

  localparam int unsigned STW = $clog2(STARVE_MAX + 1);
  localparam logic [STW-1:0] STARVE_TOP = STW'(STARVE_MAX);

  arb_state_e          state_q;
  logic [STW-1:0]      starve_q;
  logic                m_req_q, m_we_q, f_ack_q, d_ack_q, bus_err_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [DATA_W-1:0]   m_wdata_q, f_rdata_q, d_rdata_q;
  logic [DATA_W/8-1:0] m_wstrb_q;

  logic idle, fetch_wins, gnt_f, gnt_d, expire;

  // Flush vetoes a fetch grant; starvation lets a pending fetch beat data.
  assign idle       = (state_q == ST_IDLE);
  assign fetch_wins = i_f_req & ~i_flush & (~i_d_req | (starve_q == STARVE_TOP));
  assign gnt_f      = idle & fetch_wins;
  assign gnt_d      = idle & i_d_req & ~fetch_wins;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (gnt_f | gnt_d),
    .i_en     (~idle),
    .o_expire (expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      starve_q  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      bus_err_q <= 1'b0;

      if (!i_f_req || gnt_f) begin
        starve_q <= '0;
      end else if (gnt_d && starve_q != STARVE_TOP) begin
        starve_q <= starve_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (gnt_f) begin
            state_q   <= ST_FETCH;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= i_f_addr;
            m_wstrb_q <= '0;
          end else if (gnt_d) begin
            state_q   <= ST_DATA;
            m_req_q   <= 1'b1;
            m_we_q    <= i_d_we;
            m_addr_q  <= i_d_addr;
            m_wdata_q <= i_d_wdata;
            m_wstrb_q <= i_d_wstrb;
          end
        end
        ST_FETCH: begin
          if (i_m_ack) begin
            state_q <= ST_IDLE;
            m_req_q <= 1'b0;
            if (!i_flush) begin
              f_rdata_q <= i_m_rdata;
              f_ack_q   <= 1'b1;
            end
          end else if (expire) begin
            state_q   <= ST_IDLE;
            m_req_q   <= 1'b0;
            bus_err_q <= 1'b1;
            f_rdata_q <= '0;
            f_ack_q   <= ~i_flush;
          end else if (i_flush) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DATA: begin
          if (i_m_ack || expire) begin
            state_q   <= ST_IDLE;
            m_req_q   <= 1'b0;
            d_ack_q   <= 1'b1;
            bus_err_q <= ~i_m_ack;
            if (!m_we_q) d_rdata_q <= i_m_ack ? i_m_rdata : '0;
          end
        end
        ST_DRAIN: begin
          // The flushed fetch is still in flight at memory; swallow its completion.
          if (i_m_ack || expire) begin
            state_q   <= ST_IDLE;
            m_req_q   <= 1'b0;
            bus_err_q <= ~i_m_ack;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_m_req   = m_req_q;
  assign o_m_we    = m_we_q;
  assign o_m_addr  = m_addr_q;
  assign o_m_wdata = m_wdata_q;
  assign o_m_wstrb = m_wstrb_q;
  assign o_f_ack   = f_ack_q;
  assign o_d_ack   = d_ack_q;
  assign o_f_rdata = f_rdata_q;
  assign o_d_rdata = d_rdata_q;
  assign o_bus_err = bus_err_q;
  assign o_f_stall = i_f_req & ~f_ack_q;
  assign o_d_stall = i_d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - vector table plus corner sequences, acks scored against a queue
module tb_mem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_f_req, i_flush, i_d_req, i_d_we, i_m_ack;
  logic [31:0] i_f_addr, i_d_addr, i_d_wdata, i_m_rdata;
  logic [3:0]  i_d_wstrb;
  logic        o_f_ack, o_f_stall, o_d_ack, o_d_stall, o_m_req, o_m_we, o_bus_err;
  logic [31:0] o_f_rdata, o_d_rdata, o_m_addr, o_m_wdata;
  logic [3:0]  o_m_wstrb;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_f_req(i_f_req), .i_f_addr(i_f_addr), .o_f_ack(o_f_ack), .o_f_rdata(o_f_rdata),
    .o_f_stall(o_f_stall), .i_flush(i_flush),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .i_d_wstrb(i_d_wstrb), .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata), .o_d_stall(o_d_stall),
    .o_m_req(o_m_req), .o_m_we(o_m_we), .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata),
    .o_m_wstrb(o_m_wstrb), .i_m_ack(i_m_ack), .i_m_rdata(i_m_rdata), .o_bus_err(o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] f_q[$];
  logic [31:0] d_q[$];
  logic [7:0]  glog[$];
  int          f_ack_seen = 0;

  int          mem_wait  = -1;
  logic [31:0] mem_rdata = 32'h0;
  logic        force_ack = 1'b0;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wt;
    logic [31:0] mdata;
    int          exp_lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Memory responder: acks after mem_wait cycles of o_m_req (never when negative).
  initial begin
    int cyc;
    cyc = 0;
    i_m_ack = 1'b0;
    i_m_rdata = 32'h0;
    forever begin
      @(negedge i_clk);
      #1;
      if (o_m_req) begin
        i_m_ack = force_ack | ((mem_wait >= 0) && (cyc == mem_wait));
        cyc++;
      end else begin
        i_m_ack = force_ack;
        cyc = 0;
      end
      i_m_rdata = mem_rdata;
    end
  end

  // Monitor: score acks against expectation queues and log grant order.
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_m_req && !prev_req) glog.push_back(o_m_addr[8] ? 8'h46 : 8'h44);
      prev_req = o_m_req;
      if (o_f_ack) begin
        f_ack_seen++;
        if (f_q.size() == 0) chk("f_ack_unexpected", 64'(o_f_ack), 64'h0);
        else chk("f_rdata", 64'(o_f_rdata), 64'(f_q.pop_front()));
      end
      if (o_d_ack) begin
        if (d_q.size() == 0) chk("d_ack_unexpected", 64'(o_d_ack), 64'h0);
        else chk("d_rdata", 64'(o_d_rdata), 64'(d_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    lat, cnt;
    logic  port_bad, got;
    string exp_s, got_s;

    vt[0] = '{0, 32'h100, 32'h0,        4'h0, 3, 32'h00000013, 5, 32'h00000013};
    vt[1] = '{1, 32'h200, 32'h0,        4'h0, 0, 32'hA5A50001, 2, 32'hA5A50001};
    vt[2] = '{2, 32'h204, 32'hDEADBEEF, 4'h3, 2, 32'h12345678, 4, 32'hA5A50001};
    vt[3] = '{0, 32'h104, 32'h0,        4'h0, 1, 32'hFFFFFFFF, 3, 32'hFFFFFFFF};
    vt[4] = '{1, 32'h208, 32'h0,        4'h0, 5, 32'h0BADF00D, 7, 32'h0BADF00D};
    vt[5] = '{2, 32'h20C, 32'h01234567, 4'hF, 0, 32'h5A5A5A5A, 2, 32'h0BADF00D};

    i_rst_n = 1'b0;
    i_f_req = 1'b0; i_flush = 1'b0; i_d_req = 1'b0; i_d_we = 1'b0;
    i_f_addr = 32'h0; i_d_addr = 32'h0; i_d_wdata = 32'h0; i_d_wstrb = 4'h0;
    repeat (3) @(negedge i_clk);
    chk("rst_m_req", 64'(o_m_req), 64'h0);
    chk("rst_m_we", 64'(o_m_we), 64'h0);
    chk("rst_m_bus", 64'({o_m_addr, o_m_wdata}), 64'h0);
    chk("rst_m_wstrb", 64'(o_m_wstrb), 64'h0);
    chk("rst_acks", 64'({o_f_ack, o_d_ack, o_bus_err}), 64'h0);
    chk("rst_rdata", 64'({o_f_rdata, o_d_rdata}), 64'h0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int v = 0; v < 6; v++) begin
      mem_wait  = vt[v].wt;
      mem_rdata = vt[v].mdata;
      if (vt[v].kind == 0) begin
        f_q.push_back(vt[v].exp_rd);
        i_f_addr = vt[v].addr;
        i_f_req  = 1'b1;
      end else begin
        d_q.push_back(vt[v].exp_rd);
        i_d_addr  = vt[v].addr;
        i_d_we    = (vt[v].kind == 2);
        i_d_wdata = vt[v].wdata;
        i_d_wstrb = vt[v].wstrb;
        i_d_req   = 1'b1;
      end
      lat = 0;
      port_bad = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge i_clk);
        if (o_m_req) begin
          if (o_m_addr !== vt[v].addr || o_m_we !== (vt[v].kind == 2)) port_bad = 1'b1;
          if (vt[v].kind == 2 && (o_m_wdata !== vt[v].wdata || o_m_wstrb !== vt[v].wstrb))
            port_bad = 1'b1;
        end
        if ((vt[v].kind == 0 && o_f_ack) || (vt[v].kind != 0 && o_d_ack)) begin
          lat = k;
          chk($sformatf("v%0d_stall_at_ack", v), 64'(o_f_stall | o_d_stall), 64'h0);
          i_f_req = 1'b0;
          i_d_req = 1'b0;
          break;
        end
      end
      chk($sformatf("v%0d_latency", v), 64'(lat), 64'(vt[v].exp_lat));
      chk($sformatf("v%0d_port_stable", v), 64'(port_bad), 64'h0);
      repeat (2) @(negedge i_clk);
    end

    // Arbitration with starvation limit 2 under continuous requests.
    mem_wait = 0;
    mem_rdata = 32'h5555AAAA;
    repeat (2) f_q.push_back(32'h5555AAAA);
    repeat (4) d_q.push_back(32'h5555AAAA);
    glog.delete();
    i_f_addr = 32'h1C0; i_d_addr = 32'h2C0; i_d_we = 1'b0;
    i_f_req = 1'b1; i_d_req = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge i_clk);
      #2;
      if (glog.size() >= 6) break;
    end
    i_f_req = 1'b0; i_d_req = 1'b0;
    repeat (4) @(negedge i_clk);
    exp_s = "DDFDDF";
    got_s = "";
    foreach (glog[i]) got_s = $sformatf("%s%c", got_s, glog[i]);
    n_vec++;
    if (got_s != exp_s) begin
      n_fail++;
      $display("FAIL grant_order: got %s expected %s", got_s, exp_s);
    end
    chk("starve_queues_drained", 64'(f_q.size() + d_q.size()), 64'h0);

    // Flush in IDLE suppresses the grant; flush mid-fetch drains without ack.
    cnt = f_ack_seen;
    mem_wait = 2;
    mem_rdata = 32'h00000077;
    i_f_addr = 32'h180; i_f_req = 1'b1; i_flush = 1'b1;
    @(negedge i_clk);
    chk("flush_idle_no_grant", 64'(o_m_req), 64'h0);
    i_flush = 1'b0;
    @(negedge i_clk);
    chk("flush_fetch_granted", 64'(o_m_req), 64'h1);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0; i_f_req = 1'b0;
    d_q.push_back(32'h00000077);
    i_d_addr = 32'h280; i_d_we = 1'b0; i_d_req = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("drain_idle_after_ack", 64'(o_m_req), 64'h0);
    @(negedge i_clk);
    chk("drain_next_grant", 64'({o_m_req, o_m_addr}), 64'({1'b1, 32'h280}));
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_d_ack) begin got = 1'b1; i_d_req = 1'b0; break; end
    end
    chk("drain_data_ack", 64'(got), 64'h1);
    chk("drain_no_f_ack", 64'(f_ack_seen - cnt), 64'h0);
    @(negedge i_clk);

    // Flush coincident with memory ack in FETCH.
    cnt = f_ack_seen;
    mem_wait = 0;
    i_f_addr = 32'h1E0; i_f_req = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    chk("flush_ack_idle", 64'(o_m_req), 64'h0);
    i_flush = 1'b0; i_f_req = 1'b0;
    @(negedge i_clk);
    chk("flush_ack_no_f_ack", 64'(f_ack_seen - cnt), 64'h0);

    // Timeout on a load that memory never acknowledges.
    mem_wait = -1;
    d_q.push_back(32'h0);
    i_d_addr = 32'h2F0; i_d_we = 1'b0; i_d_req = 1'b1;
    cnt = 0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_bus_err) begin got = 1'b1; break; end
      if (o_m_req) cnt++;
    end
    chk("tmo_bus_err", 64'(got), 64'h1);
    chk("tmo_req_cycles", 64'(cnt), 64'd8);
    chk("tmo_d_ack_with_err", 64'({o_d_ack, o_m_req}), 64'h2);
    i_d_req = 1'b0;
    @(negedge i_clk);
    chk("tmo_err_pulse", 64'(o_bus_err), 64'h0);

    // Reset in the middle of a data transaction, then a stale ack.
    i_d_addr = 32'h2A0; i_d_req = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst_mid_busy", 64'(o_m_req), 64'h1);
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_m_bus", 64'({o_m_req, o_m_we, o_m_addr}), 64'h0);
    chk("rst_mid_flags", 64'({o_f_ack, o_d_ack, o_bus_err, o_m_wstrb}), 64'h0);
    chk("rst_mid_rdata", 64'({o_f_rdata, o_d_rdata}), 64'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_d_req = 1'b0;
    force_ack = 1'b1;
    @(negedge i_clk);
    force_ack = 1'b0;
    @(negedge i_clk);
    chk("stale_ack_ignored", 64'({o_d_ack, o_f_ack, o_m_req}), 64'h0);
    @(negedge i_clk);
    chk("stale_ack_quiet", 64'({o_d_ack, o_f_ack, o_m_req, o_bus_err}), 64'h0);
    chk("final_queues_empty", 64'(f_q.size() + d_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
